lfsr_run_ctrl: RTL

- AXI-Lite master sequencer that drives one LFSR generation run in the LFSR → histogram → RAM pipeline.
- On start it writes SEED, reads SEED back to verify, then writes CTRL.enable=1.
- It counts accepted beats on the LFSR output stream (monitor taps only) and writes CTRL.enable=0 after N beats or on timeout.
- It reports busy, done and error to the host-side control logic.

---
 rtl/lfsr_run_ctrl.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/lfsr_run_ctrl.sv
// AXI-Lite master sequencer for one LFSR generation run: program and verify SEED, enable the
// generator, count monitored stream beats (or time out), then disable and report completion.
module lfsr_run_ctrl #(
  parameter int unsigned              ADDR_WIDTH     = 4,
  parameter int unsigned              DATA_WIDTH     = 32,
  parameter int unsigned              CNT_WIDTH      = 16,
  parameter logic [ADDR_WIDTH-1:0]    CTRL_ADDR      = 'h0,
  parameter logic [ADDR_WIDTH-1:0]    SEED_ADDR      = 'h4,
  parameter int unsigned              TIMEOUT_CYCLES = 65535
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] seed,
  input  logic [CNT_WIDTH-1:0]  sample_count,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  timeout,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  input  logic                  mon_tvalid,
  input  logic                  mon_tready
);

  typedef enum logic [3:0] {
    StIdle, StWrSeed, StBSeed, StArSeed, StRSeed, StWrEn, StBEn, StRun, StWrDis, StBDis, StFin
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] seed_q, seed_d;
  logic [CNT_WIDTH-1:0]  target_q, target_d;
  logic [CNT_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
  logic [31:0]           cyc_cnt_q, cyc_cnt_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic                  error_q, error_d;
  logic                  timeout_q, timeout_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic                  in_wr;
  logic                  aw_hs;
  logic                  w_hs;
  logic                  beat;
  logic [CNT_WIDTH-1:0]  beat_cnt_inc;
  logic [31:0]           cyc_cnt_inc;

  assign in_wr = (state_q == StWrSeed) || (state_q == StWrEn) || (state_q == StWrDis);

  // Each write channel drops its valid independently once its own handshake is done.
  assign m_axi_awvalid = in_wr && !aw_done_q;
  assign m_axi_wvalid  = in_wr && !w_done_q;
  assign aw_hs         = m_axi_awvalid && m_axi_awready;
  assign w_hs          = m_axi_wvalid && m_axi_wready;
  assign m_axi_bready  = (state_q == StBSeed) || (state_q == StBEn) || (state_q == StBDis);
  assign m_axi_arvalid = (state_q == StArSeed);
  assign m_axi_rready  = (state_q == StRSeed);
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_araddr  = araddr_q;

  assign busy    = (state_q != StIdle) && (state_q != StFin);
  assign done    = (state_q == StFin);
  assign error   = error_q;
  assign timeout = timeout_q;

  assign beat         = mon_tvalid && mon_tready;
  assign beat_cnt_inc = beat_cnt_q + CNT_WIDTH'(1);
  assign cyc_cnt_inc  = cyc_cnt_q + 32'd1;

  always_comb begin
    state_d    = state_q;
    seed_d     = seed_q;
    target_d   = target_q;
    beat_cnt_d = beat_cnt_q;
    cyc_cnt_d  = cyc_cnt_q;
    aw_done_d  = aw_done_q || aw_hs;
    w_done_d   = w_done_q || w_hs;
    error_d    = error_q;
    timeout_d  = timeout_q;
    awaddr_d   = awaddr_q;
    araddr_d   = araddr_q;
    wdata_d    = wdata_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          seed_d    = seed;
          target_d  = sample_count;
          error_d   = 1'b0;
          timeout_d = 1'b0;
          awaddr_d  = SEED_ADDR;
          wdata_d   = seed;
          state_d   = StWrSeed;
        end
      end
      StWrSeed, StWrEn, StWrDis: begin
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (state_q == StWrSeed)    state_d = StBSeed;
          else if (state_q == StWrEn) state_d = StBEn;
          else                        state_d = StBDis;
        end
      end
      StBSeed: begin
        if (m_axi_bvalid) begin
          if (m_axi_bresp != 2'b00) begin
            error_d = 1'b1;
            state_d = StFin;
          end else begin
            araddr_d = SEED_ADDR;
            state_d  = StArSeed;
          end
        end
      end
      StArSeed: begin
        if (m_axi_arready) state_d = StRSeed;
      end
      StRSeed: begin
        if (m_axi_rvalid) begin
          if ((m_axi_rresp != 2'b00) || (m_axi_rdata != seed_q)) begin
            error_d = 1'b1;
            state_d = StFin;
          end else begin
            awaddr_d = CTRL_ADDR;
            wdata_d  = DATA_WIDTH'(1);
            state_d  = StWrEn;
          end
        end
      end
      StBEn: begin
        // A failed enable still runs so that the disable write is always attempted.
        if (m_axi_bvalid) begin
          if (m_axi_bresp != 2'b00) error_d = 1'b1;
          beat_cnt_d = '0;
          cyc_cnt_d  = '0;
          if (target_q == '0) begin
            awaddr_d = CTRL_ADDR;
            wdata_d  = '0;
            state_d  = StWrDis;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        cyc_cnt_d = cyc_cnt_inc;
        if (beat) beat_cnt_d = beat_cnt_inc;
        // Count completion has priority over a timeout landing in the same cycle.
        if (beat && (beat_cnt_inc == target_q)) begin
          awaddr_d = CTRL_ADDR;
          wdata_d  = '0;
          state_d  = StWrDis;
        end else if ((TIMEOUT_CYCLES != 0) && (cyc_cnt_inc == TIMEOUT_CYCLES)) begin
          timeout_d = 1'b1;
          error_d   = 1'b1;
          awaddr_d  = CTRL_ADDR;
          wdata_d   = '0;
          state_d   = StWrDis;
        end
      end
      StBDis: begin
        if (m_axi_bvalid) begin
          if (m_axi_bresp != 2'b00) error_d = 1'b1;
          state_d = StFin;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q    <= StIdle;
      seed_q     <= '0;
      target_q   <= '0;
      beat_cnt_q <= '0;
      cyc_cnt_q  <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      error_q    <= 1'b0;
      timeout_q  <= 1'b0;
      awaddr_q   <= '0;
      araddr_q   <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      seed_q     <= seed_d;
      target_q   <= target_d;
      beat_cnt_q <= beat_cnt_d;
      cyc_cnt_q  <= cyc_cnt_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      error_q    <= error_d;
      timeout_q  <= timeout_d;
      awaddr_q   <= awaddr_d;
      araddr_q   <= araddr_d;
      wdata_q    <= wdata_d;
    end
  end

endmodule
